// File: rtl/dcache_set_assoc.sv
// dcache_set_assoc: N-way set-associative, write-back, write-allocate data cache.
// Miss handling writes back a dirty victim beat by beat, then refills the line one beat at a time.
// Replacement picks the lowest invalid way, else a per-set round-robin pointer.
// Optional macro DCACHE_PERF_COUNTERS_EN adds hit_count/miss_count/wb_count outputs.
module dcache_set_assoc #(
  parameter int unsigned LINE_SIZE  = 32,
  parameter int unsigned CACHE_SIZE = 1024,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned XLEN       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
`ifdef DCACHE_PERF_COUNTERS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count,
`endif
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  localparam int unsigned WORD_BYTES = XLEN / 8;
  localparam int unsigned BEATS      = LINE_SIZE / WORD_BYTES;
  localparam int unsigned NUM_SETS   = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
  localparam int unsigned WOFS       = $clog2(WORD_BYTES);
  localparam int unsigned OFS_SIZE   = $clog2(LINE_SIZE);
  localparam int unsigned SET_SIZE   = $clog2(NUM_SETS);
  localparam int unsigned TAG_SIZE   = XLEN - OFS_SIZE - SET_SIZE;
  localparam int unsigned SET_POS    = OFS_SIZE;
  localparam int unsigned TAG_POS    = OFS_SIZE + SET_SIZE;
  localparam int unsigned BEAT_W     = OFS_SIZE - WOFS;
  localparam int unsigned WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StRefillReq, StRefillWait} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [WORD_BYTES-1:0] wstrb_q, wstrb_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [WAY_W-1:0]    rr_q [NUM_SETS];
  logic [WAY_W-1:0]    rr_d [NUM_SETS];

  logic [TAG_SIZE-1:0] tag_mem  [NUM_WAYS][NUM_SETS];
  logic [XLEN-1:0]     data_mem [NUM_WAYS][NUM_SETS][BEATS];

  logic [SET_SIZE-1:0] set_idx;
  logic [TAG_SIZE-1:0] req_tag;
  logic [BEAT_W-1:0]   word_idx;
  logic                hit, inv_found, evict_dirty, last_beat;
  logic [WAY_W-1:0]    hit_way, inv_way, victim_sel;
  logic [XLEN-1:0]     hit_word, merged_word;
  logic                data_we, tag_we;
  logic [WAY_W-1:0]    data_way;
  logic [BEAT_W-1:0]   data_beat;
  logic [XLEN-1:0]     data_wdata;
  logic                unused_addr_lo;

  assign set_idx        = addr_q[SET_POS +: SET_SIZE];
  assign req_tag        = addr_q[TAG_POS +: TAG_SIZE];
  assign word_idx       = addr_q[WOFS +: BEAT_W];
  assign unused_addr_lo = ^addr_q[WOFS-1:0];
  assign last_beat      = (beat_q == BEAT_W'(BEATS - 1));
  assign victim_sel     = inv_found ? inv_way : rr_q[set_idx];
  assign evict_dirty    = valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel];
  assign hit_word       = data_mem[hit_way][set_idx][word_idx];

  // Tag lookup over all ways, plus lowest-index invalid way for victim choice.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[set_idx][w] && (tag_mem[w][set_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Byte-merge of store data into the hit word.
  always_comb begin
    merged_word = hit_word;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (wstrb_q[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Controller next state, array write controls and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    beat_d        = beat_q;
    victim_d      = victim_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    rr_d          = rr_q;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    data_way      = victim_q;
    data_beat     = beat_q;
    data_wdata    = mem_resp_rdata;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = we_q ? '0 : hit_word;
          if (we_q) begin
            data_we                   = 1'b1;
            data_way                  = hit_way;
            data_beat                 = word_idx;
            data_wdata                = merged_word;
            dirty_d[set_idx][hit_way] = 1'b1;
          end
          state_d = StIdle;
        end else begin
          victim_d                     = victim_sel;
          // Victim is dropped now so a reset or abort never leaves a half-filled valid line.
          valid_d[set_idx][victim_sel] = 1'b0;
          beat_d                       = '0;
          state_d                      = evict_dirty ? StWriteback : StRefillReq;
        end
      end
      StWriteback: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_mem[victim_q][set_idx], set_idx, beat_q, WOFS'(0)};
        mem_req_wdata = data_mem[victim_q][set_idx][beat_q];
        if (mem_req_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) state_d = StRefillReq;
        end
      end
      StRefillReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, set_idx, beat_q, WOFS'(0)};
        if (mem_req_ready) state_d = StRefillWait;
      end
      StRefillWait: begin
        if (mem_resp_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + BEAT_W'(1);
          if (last_beat) begin
            tag_we                     = 1'b1;
            valid_d[set_idx][victim_q] = 1'b1;
            dirty_d[set_idx][victim_q] = 1'b0;
            rr_d[set_idx] = (rr_q[set_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                    : rr_q[set_idx] + WAY_W'(1);
            state_d       = StCompare;
          end else begin
            state_d = StRefillReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state and per-set metadata registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      beat_q   <= '0;
      victim_q <= '0;
      valid_q  <= '{default: '0};
      dirty_q  <= '{default: '0};
      rr_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      rr_q     <= rr_d;
    end
  end

  // Tag and data arrays; contents are meaningful only under a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && tag_we) tag_mem[victim_q][set_idx] <= req_tag;
    if (!reset && data_we) data_mem[data_way][set_idx][data_beat] <= data_wdata;
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  logic        first_q, first_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Counts only the first COMPARE of a request; the post-refill COMPARE is not a new access.
  always_comb begin
    first_d    = first_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == StIdle && req_valid) first_d = 1'b1;
    if (state_q == StCompare) begin
      first_d = 1'b0;
      if (first_q && hit) hit_cnt_d = sat_inc(hit_cnt_q);
      if (first_q && !hit) miss_cnt_d = sat_inc(miss_cnt_q);
      if (!hit && evict_dirty) wb_cnt_d = sat_inc(wb_cnt_q);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule
